// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-stage sequencer.
//   fetch_state_t      : sequencer states
//   INSN_BYTES         : byte stride between consecutive instructions
//   DEFAULT_RESET_VEC  : default first fetch address after reset
//   DEFAULT_TRAP_VEC   : default redirect target for traps and misaligned branches
//   is_misaligned()    : true when an address is not word aligned
package fetch_pkg;

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        HOLD,
        DRAIN,
        HALT
    } fetch_state_t;

    localparam int unsigned INSN_BYTES        = 4;
    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VEC  = 32'h0000_0100;

    // Only the two low address bits decide word alignment.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus.
//   imem_req   : request, held until imem_ack
//   imem_addr  : request address, stable while imem_req is high
//   imem_ack   : response valid, completes the current request
//   imem_rdata : instruction word, valid with imem_ack
// master = fetch sequencer side, slave = memory side.
interface fetch_ctrl_if #(
    parameter int XLEN = 32
) ();

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_skid.sv
// One-entry instruction/PC holding buffer. Catches a response that
// arrives while decode is still stalled on the previous word.
//   clk, rst      : clock and synchronous active-high reset
//   push          : capture push_instr/push_pc, entry becomes full
//   pop           : entry consumed, becomes empty
//   flush         : discard the entry (wins over push and pop)
//   full          : entry holds a word
//   out_instr/pc  : stored instruction and its address
module fetch_skid #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] push_instr,
    input  logic [XLEN-1:0] push_pc,
    output logic            full,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
);

    logic            full_q, full_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;

    // Next-entry logic: a redirect flush overrides everything, otherwise
    // a push loads the entry and a pop empties it.
    always_comb begin
        full_d  = full_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            full_d = 1'b0;
        end else if (push) begin
            full_d  = 1'b1;
            instr_d = push_instr;
            pc_d    = push_pc;
        end else if (pop) begin
            full_d = 1'b0;
        end
    end

    // Entry registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q  <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            full_q  <= full_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign full      = full_q;
    assign out_instr = instr_q;
    assign out_pc    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer. Issues instruction-memory requests, delivers
// instruction/PC pairs to decode, applies trap/branch redirects and
// drives the PC register update.
//   clk, rst      : clock and synchronous active-high reset
//   imem          : instruction-memory bus (master side)
//   hz_stall      : decode not accepting, if_* must hold
//   br_taken/br_target : branch redirect pulse and target from EX
//   trap_req      : trap redirect pulse (beats branch)
//   halt_req      : stop fetching after the current request completes
//   if_valid/if_instr/if_pc : word handed to decode
//   next_pc/pc_stall : PC register load value and hold
//   misalign_err  : one-cycle pulse for a misaligned branch target
//   halted        : sequencer is in HALT
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = DEFAULT_RESET_VEC,
    parameter logic [XLEN-1:0] TRAP_VEC  = DEFAULT_TRAP_VEC
) (
    input  logic            clk,
    input  logic            rst,
    fetch_ctrl_if.master    imem,
    input  logic            hz_stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            trap_req,
    input  logic            halt_req,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] next_pc,
    output logic            pc_stall,
    output logic            misalign_err,
    output logic            halted
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] if_instr_q, if_instr_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic            misalign_q, misalign_d;
    logic            halt_pend_q, halt_pend_d;

    logic            fetch_pc_we;
    logic            out_free;
    logic            halt_pend;
    logic            br_effective;
    logic            br_misaligned;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;

    logic            skid_push, skid_pop, skid_flush, skid_full;
    logic [XLEN-1:0] skid_instr, skid_pc;

    fetch_skid #(.XLEN(XLEN)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (skid_push),
        .pop        (skid_pop),
        .flush      (skid_flush),
        .push_instr (imem.imem_rdata),
        .push_pc    (req_addr_q),
        .full       (skid_full),
        .out_instr  (skid_instr),
        .out_pc     (skid_pc)
    );

    // Redirect resolution. A trap always wins and goes to the trap vector;
    // a branch is ignored while halted and a misaligned branch target is
    // turned into a trap-vector redirect with an error pulse.
    always_comb begin
        br_effective    = br_taken && (state_q != HALT);
        br_misaligned   = br_effective && !trap_req && is_misaligned(br_target[1:0]);
        redirect        = trap_req || br_effective;
        redirect_target = (trap_req || br_misaligned) ? TRAP_VEC : br_target;
    end

    // Next-state and datapath logic. Decode drains if_* on a transfer
    // unless a new word replaces it in the same cycle. A redirect kills
    // everything in flight; an outstanding request is drained because the
    // memory must still see it complete.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        fetch_pc_we = 1'b0;
        req_addr_d  = req_addr_q;
        if_valid_d  = if_valid_q && hz_stall;
        if_instr_d  = if_instr_q;
        if_pc_d     = if_pc_q;
        skid_push   = 1'b0;
        skid_pop    = 1'b0;
        skid_flush  = 1'b0;
        out_free    = !if_valid_q || !hz_stall;
        halt_pend   = halt_pend_q || halt_req;

        if (redirect) begin
            fetch_pc_d  = redirect_target;
            fetch_pc_we = 1'b1;
            if_valid_d  = 1'b0;
            skid_flush  = 1'b1;
            unique case (state_q)
                REQ, DRAIN: state_d = imem.imem_ack ? REQ : DRAIN;
                default:    state_d = REQ;
            endcase
        end else begin
            unique case (state_q)
                BOOT: state_d = REQ;
                REQ: begin
                    if (imem.imem_ack) begin
                        fetch_pc_d  = fetch_pc_q + XLEN'(INSN_BYTES);
                        fetch_pc_we = 1'b1;
                        if (out_free) begin
                            if_valid_d = 1'b1;
                            if_instr_d = imem.imem_rdata;
                            if_pc_d    = req_addr_q;
                            state_d    = halt_pend ? HALT : REQ;
                        end else begin
                            // Decode still holds the previous word; park
                            // this one and stop requesting until it drains.
                            skid_push = 1'b1;
                            state_d   = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!hz_stall && skid_full) begin
                        if_valid_d = 1'b1;
                        if_instr_d = skid_instr;
                        if_pc_d    = skid_pc;
                        skid_pop   = 1'b1;
                        state_d    = halt_pend ? HALT : REQ;
                    end
                end
                DRAIN: begin
                    if (imem.imem_ack) begin
                        state_d = halt_pend ? HALT : REQ;
                    end
                end
                HALT:    state_d = HALT;
                default: state_d = BOOT;
            endcase
        end

        // A fresh request starts whenever REQ is entered or re-entered
        // after an ack; a request still waiting keeps its address.
        if ((state_d == REQ) && !((state_q == REQ) && !imem.imem_ack)) begin
            req_addr_d = fetch_pc_d;
        end

        halt_pend_d = halt_pend && (state_q != HALT) && (state_d != HALT);
        misalign_d  = br_misaligned;
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BOOT;
            fetch_pc_q  <= RESET_VEC;
            req_addr_q  <= '0;
            if_valid_q  <= 1'b0;
            if_instr_q  <= '0;
            if_pc_q     <= '0;
            misalign_q  <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_addr_q  <= req_addr_d;
            if_valid_q  <= if_valid_d;
            if_instr_q  <= if_instr_d;
            if_pc_q     <= if_pc_d;
            misalign_q  <= misalign_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign imem.imem_req  = (state_q == REQ) || (state_q == DRAIN);
    assign imem.imem_addr = req_addr_q;
    assign if_valid       = if_valid_q;
    assign if_instr       = if_instr_q;
    assign if_pc          = if_pc_q;
    assign next_pc        = fetch_pc_d;
    assign pc_stall       = !fetch_pc_we;
    assign misalign_err   = misalign_q;
    assign halted         = (state_q == HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios plus a randomized stream
// checked against a transaction-level model of the decode stream.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        hz_stall, br_taken, trap_req, halt_req;
    logic [31:0] br_target;
    logic        if_valid, pc_stall, misalign_err, halted;
    logic [31:0] if_instr, if_pc, next_pc;

    int total = 0;
    int bad   = 0;

    fetch_ctrl_if #(.XLEN(32)) imem_bus ();

    fetch_ctrl #(
        .XLEN      (32),
        .RESET_VEC (32'h0000_0000),
        .TRAP_VEC  (32'h0000_0100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem         (imem_bus),
        .hz_stall     (hz_stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .trap_req     (trap_req),
        .halt_req     (halt_req),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .next_pc      (next_pc),
        .pc_stall     (pc_stall),
        .misalign_err (misalign_err),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // Memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]} ^ {a[31:16], 16'h0};
    endfunction

    // Move to the next negedge and drop all single-cycle pulses.
    task automatic next_cycle();
        @(negedge clk);
        imem_bus.imem_ack = 1'b0;
        br_taken          = 1'b0;
        trap_req          = 1'b0;
        halt_req          = 1'b0;
    endtask

    // Hold reset over two edges, release it at a negedge (state is BOOT).
    task automatic do_reset();
        rst                 = 1'b1;
        hz_stall            = 1'b0;
        br_taken            = 1'b0;
        br_target           = 32'h0;
        trap_req            = 1'b0;
        halt_req            = 1'b0;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst                 = 1'b1;
        hz_stall            = 1'b0;
        br_taken            = 1'b0;
        br_target           = 32'h0;
        trap_req            = 1'b0;
        halt_req            = 1'b0;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (imem_bus.imem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req got=%b exp=0", imem_bus.imem_req); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_if_valid got=%b exp=0", if_valid); end
        total++; if (if_instr !== 32'h0) begin bad++; $display("[TB] FAIL reset_if_instr got=%h exp=0", if_instr); end
        total++; if (if_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_if_pc got=%h exp=0", if_pc); end
        total++; if (misalign_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_misalign got=%b exp=0", misalign_err); end
        total++; if (halted !== 1'b0) begin bad++; $display("[TB] FAIL reset_halted got=%b exp=0", halted); end
        total++; if (next_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_next_pc got=%h exp=0", next_pc); end
        rst = 1'b0;
        #1;
        total++; if (imem_bus.imem_req !== 1'b0) begin bad++; $display("[TB] FAIL boot_req got=%b exp=0", imem_bus.imem_req); end
    endtask

    task automatic test_stream();
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            a = 32'(4 * i);
            next_cycle();
            imem_bus.imem_ack   = 1'b1;
            imem_bus.imem_rdata = mem_word(a);
            #1;
            total++; if (imem_bus.imem_req !== 1'b1) begin bad++; $display("[TB] FAIL stream_req got=%b exp=1", imem_bus.imem_req); end
            total++; if (imem_bus.imem_addr !== a) begin bad++; $display("[TB] FAIL stream_addr got=%h exp=%h", imem_bus.imem_addr, a); end
            total++; if (next_pc !== a + 32'd4) begin bad++; $display("[TB] FAIL stream_next_pc got=%h exp=%h", next_pc, a + 32'd4); end
            total++; if (pc_stall !== 1'b0) begin bad++; $display("[TB] FAIL stream_pc_stall got=%b exp=0", pc_stall); end
            if (i > 0) begin
                total++; if (if_valid !== 1'b1 || if_pc !== a - 32'd4) begin bad++; $display("[TB] FAIL stream_if_pc got=%b/%h exp=1/%h", if_valid, if_pc, a - 32'd4); end
                total++; if (if_instr !== mem_word(a - 32'd4)) begin bad++; $display("[TB] FAIL stream_if_instr got=%h exp=%h", if_instr, mem_word(a - 32'd4)); end
            end else begin
                total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL stream_first_valid got=%b exp=0", if_valid); end
            end
        end
        next_cycle();
        #1;
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h8) begin bad++; $display("[TB] FAIL stream_last_pc got=%b/%h exp=1/8", if_valid, if_pc); end
        total++; if (pc_stall !== 1'b1 || next_pc !== 32'hC) begin bad++; $display("[TB] FAIL stream_idle_pc got=%b/%h exp=1/c", pc_stall, next_pc); end
        next_cycle();
        #1;
        total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL stream_drop_valid got=%b exp=0", if_valid); end
    endtask

    task automatic test_stall();
        do_reset();
        next_cycle();
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = mem_word(32'h0);
        next_cycle();
        hz_stall            = 1'b1;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = mem_word(32'h4);
        #1;
        total++; if (imem_bus.imem_addr !== 32'h4) begin bad++; $display("[TB] FAIL stall_addr got=%h exp=4", imem_bus.imem_addr); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            if (i == 2) hz_stall = 1'b0;
            #1;
            total++; if (imem_bus.imem_req !== 1'b0) begin bad++; $display("[TB] FAIL stall_hold_req got=%b exp=0", imem_bus.imem_req); end
            total++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== mem_word(32'h0)) begin bad++; $display("[TB] FAIL stall_hold_if got=%b/%h/%h exp=1/0/%h", if_valid, if_pc, if_instr, mem_word(32'h0)); end
        end
        next_cycle();
        #1;
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== mem_word(32'h4)) begin bad++; $display("[TB] FAIL stall_skid_out got=%b/%h/%h exp=1/4/%h", if_valid, if_pc, if_instr, mem_word(32'h4)); end
        total++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h8) begin bad++; $display("[TB] FAIL stall_resume got=%b/%h exp=1/8", imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    task automatic test_branch_drain();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            imem_bus.imem_ack   = 1'b1;
            imem_bus.imem_rdata = mem_word(32'(4 * i));
        end
        next_cycle();
        br_taken  = 1'b1;
        br_target = 32'h200;
        #1;
        total++; if (imem_bus.imem_addr !== 32'h10) begin bad++; $display("[TB] FAIL br_pending_addr got=%h exp=10", imem_bus.imem_addr); end
        total++; if (next_pc !== 32'h200 || pc_stall !== 1'b0) begin bad++; $display("[TB] FAIL br_next_pc got=%h/%b exp=200/0", next_pc, pc_stall); end
        next_cycle();
        #1;
        total++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h10 || if_valid !== 1'b0) begin bad++; $display("[TB] FAIL br_drain got=%b/%h/%b exp=1/10/0", imem_bus.imem_req, imem_bus.imem_addr, if_valid); end
        next_cycle();
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        #1;
        total++; if (pc_stall !== 1'b1) begin bad++; $display("[TB] FAIL br_drain_stall got=%b exp=1", pc_stall); end
        next_cycle();
        #1;
        total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL br_stale_dropped got=%b exp=0", if_valid); end
        total++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h200) begin bad++; $display("[TB] FAIL br_new_addr got=%b/%h exp=1/200", imem_bus.imem_req, imem_bus.imem_addr); end
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = mem_word(32'h200);
        next_cycle();
        #1;
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== mem_word(32'h200)) begin bad++; $display("[TB] FAIL br_first_word got=%b/%h/%h exp=1/200/%h", if_valid, if_pc, if_instr, mem_word(32'h200)); end
    endtask

    task automatic test_trap_priority();
        do_reset();
        next_cycle();
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = mem_word(32'h0);
        trap_req            = 1'b1;
        br_taken            = 1'b1;
        br_target           = 32'h300;
        #1;
        total++; if (next_pc !== 32'h100) begin bad++; $display("[TB] FAIL trap_next_pc got=%h exp=100", next_pc); end
        next_cycle();
        #1;
        total++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h100) begin bad++; $display("[TB] FAIL trap_addr got=%b/%h exp=1/100", imem_bus.imem_req, imem_bus.imem_addr); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL trap_discard got=%b exp=0", if_valid); end
        total++; if (misalign_err !== 1'b0) begin bad++; $display("[TB] FAIL trap_no_misalign got=%b exp=0", misalign_err); end
    endtask

    task automatic test_misaligned();
        do_reset();
        next_cycle();
        br_taken  = 1'b1;
        br_target = 32'h202;
        #1;
        total++; if (next_pc !== 32'h100) begin bad++; $display("[TB] FAIL mis_next_pc got=%h exp=100", next_pc); end
        next_cycle();
        #1;
        total++; if (misalign_err !== 1'b1) begin bad++; $display("[TB] FAIL mis_pulse got=%b exp=1", misalign_err); end
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h1234_5678;
        next_cycle();
        #1;
        total++; if (misalign_err !== 1'b0) begin bad++; $display("[TB] FAIL mis_pulse_end got=%b exp=0", misalign_err); end
        total++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h100) begin bad++; $display("[TB] FAIL mis_resume got=%b/%h exp=1/100", imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    task automatic test_halt_and_wrap();
        do_reset();
        next_cycle();
        halt_req = 1'b1;
        #1;
        total++; if (halted !== 1'b0) begin bad++; $display("[TB] FAIL halt_early got=%b exp=0", halted); end
        next_cycle();
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = mem_word(32'h0);
        next_cycle();
        #1;
        total++; if (halted !== 1'b1 || imem_bus.imem_req !== 1'b0) begin bad++; $display("[TB] FAIL halt_enter got=%b/%b exp=1/0", halted, imem_bus.imem_req); end
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== mem_word(32'h0)) begin bad++; $display("[TB] FAIL halt_data got=%b/%h/%h exp=1/0/%h", if_valid, if_pc, if_instr, mem_word(32'h0)); end
        next_cycle();
        br_taken  = 1'b1;
        br_target = 32'h202;
        #1;
        total++; if (pc_stall !== 1'b1 || next_pc !== 32'h4) begin bad++; $display("[TB] FAIL halt_br_ignored got=%b/%h exp=1/4", pc_stall, next_pc); end
        next_cycle();
        #1;
        total++; if (halted !== 1'b1 || misalign_err !== 1'b0 || imem_bus.imem_req !== 1'b0) begin bad++; $display("[TB] FAIL halt_stay got=%b/%b/%b exp=1/0/0", halted, misalign_err, imem_bus.imem_req); end
        trap_req = 1'b1;
        #1;
        total++; if (next_pc !== 32'h100 || pc_stall !== 1'b0) begin bad++; $display("[TB] FAIL halt_trap_pc got=%h/%b exp=100/0", next_pc, pc_stall); end
        next_cycle();
        #1;
        total++; if (halted !== 1'b0 || imem_bus.imem_addr !== 32'h100 || imem_bus.imem_req !== 1'b1) begin bad++; $display("[TB] FAIL halt_exit got=%b/%h/%b exp=0/100/1", halted, imem_bus.imem_addr, imem_bus.imem_req); end
        // Wrap-around: branch to the last word of the address space.
        br_taken            = 1'b1;
        br_target           = 32'hFFFF_FFFC;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h0BAD_0BAD;
        next_cycle();
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = mem_word(32'hFFFF_FFFC);
        #1;
        total++; if (imem_bus.imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_addr got=%h exp=fffffffc", imem_bus.imem_addr); end
        total++; if (next_pc !== 32'h0) begin bad++; $display("[TB] FAIL wrap_next_pc got=%h exp=0", next_pc); end
        next_cycle();
        #1;
        total++; if (imem_bus.imem_addr !== 32'h0 || if_pc !== 32'hFFFF_FFFC || if_valid !== 1'b1) begin bad++; $display("[TB] FAIL wrap_after got=%h/%h/%b exp=0/fffffffc/1", imem_bus.imem_addr, if_pc, if_valid); end
    endtask

    // Random memory latency, decode stalls and redirects. The model only
    // tracks what decode must see: consecutive words from the current
    // stream start, restarting at each redirect's effective target.
    task automatic test_random();
        logic [31:0] exp_pc, tgt, prev_addr;
        logic        exp_mis, prev_wait;
        int          delay, xfers, r;
        do_reset();
        exp_pc    = 32'h0;
        exp_mis   = 1'b0;
        prev_wait = 1'b0;
        prev_addr = 32'h0;
        delay     = -1;
        xfers     = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            next_cycle();
            hz_stall = ($urandom_range(0, 3) == 0);
            if (imem_bus.imem_req === 1'b1) begin
                if (delay < 0) delay = int'($urandom_range(0, 3));
                if (delay == 0) begin
                    imem_bus.imem_ack   = 1'b1;
                    imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
                    delay               = -1;
                end else begin
                    delay--;
                end
            end else begin
                delay = -1;
            end
            r   = int'($urandom_range(0, 24));
            tgt = $urandom & 32'h0000_3FFC;
            if (r == 2) tgt[1:0] = 2'(1 + $urandom_range(0, 2));
            if (r <= 2) begin
                br_taken  = 1'b1;
                br_target = tgt;
            end
            if (r == 0) trap_req = 1'b1;
            #1;
            if (prev_wait) begin
                total++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== prev_addr) begin bad++; $display("[TB] FAIL rnd_req_stable got=%b/%h exp=1/%h", imem_bus.imem_req, imem_bus.imem_addr, prev_addr); end
            end
            total++; if (misalign_err !== exp_mis) begin bad++; $display("[TB] FAIL rnd_misalign got=%b exp=%b", misalign_err, exp_mis); end
            if (if_valid === 1'b1 && !hz_stall) begin
                total++; if (if_pc !== exp_pc || if_instr !== mem_word(exp_pc)) begin bad++; $display("[TB] FAIL rnd_xfer got=%h/%h exp=%h/%h", if_pc, if_instr, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                xfers++;
            end
            exp_mis = br_taken && !trap_req && (br_target[1:0] != 2'b00);
            if (trap_req || exp_mis) exp_pc = 32'h100;
            else if (br_taken) exp_pc = br_target;
            prev_wait = (imem_bus.imem_req === 1'b1) && !imem_bus.imem_ack;
            prev_addr = imem_bus.imem_addr;
        end
        total++; if (xfers < 150) begin bad++; $display("[TB] FAIL rnd_progress got=%0d exp>=150", xfers); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_branch_drain();
        test_trap_priority();
        test_misaligned();
        test_halt_and_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
